// File: rtl/dice_cfg_loader.sv
// DICE CGRA configuration loader: deserializes a word stream into shadow registers and commits
// them atomically to the active outputs. Define DICE_CFG_LOADER_CHECKSUM_EN for an XOR trailer.
module dice_cfg_loader #(
   parameter int unsigned TILE_BITS           = 156,
   parameter int unsigned NUM_TILES           = 16,
   parameter int unsigned NUM_CGRA_IO         = 32,
   parameter int unsigned PRED_BITS           = 8,
   parameter int unsigned GPRF_BITS           = 49,
   parameter int unsigned CGRA_PIPE_SEL_WIDTH = 5
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr,
   input  logic                                 start,
   input  logic [31:0]                          in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [PRED_BITS*NUM_CGRA_IO-1:0]     predrf_cfg,
   output logic [GPRF_BITS*NUM_CGRA_IO-1:0]     gprf_cfg,
   output logic [TILE_BITS*NUM_TILES-1:0]       cgra_cfg,
   output logic [CGRA_PIPE_SEL_WIDTH-1:0]       cgra_compute_latency,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);
   localparam int unsigned PredWords = (PRED_BITS + 31) / 32;
   localparam int unsigned GprfWords = (GPRF_BITS + 31) / 32;
   localparam int unsigned CgraWords = (TILE_BITS + 31) / 32;
   localparam int unsigned MaxWords0 = (GprfWords > PredWords) ? GprfWords : PredWords;
   localparam int unsigned MaxWords  = (CgraWords > MaxWords0) ? CgraWords : MaxWords0;
   localparam int unsigned AccW      = 32 * ((MaxWords > 1) ? MaxWords - 1 : 1);
   localparam int unsigned WordW     = (MaxWords > 1) ? $clog2(MaxWords) : 1;
   localparam int unsigned MaxRecs   = (NUM_CGRA_IO > NUM_TILES) ? NUM_CGRA_IO : NUM_TILES;
   localparam int unsigned RecW      = (MaxRecs > 1) ? $clog2(MaxRecs) : 1;
   localparam int unsigned PredTot   = PRED_BITS * NUM_CGRA_IO;
   localparam int unsigned GprfTot   = GPRF_BITS * NUM_CGRA_IO;
   localparam int unsigned CgraTot   = TILE_BITS * NUM_TILES;

   typedef enum logic [2:0] {StIdle, StPred, StGprf, StCgra, StLat, StChk, StCommit} state_e;

   state_e                         state_q, state_d;
   logic [WordW-1:0]               word_q, word_d, last_word;
   logic [RecW-1:0]                rec_q, rec_d, last_rec;
   logic                           hs, rec_last, sec_last;
   logic [AccW-1:0]                acc_q;
   logic [PredTot-1:0]             pred_sh_q, pred_act_q;
   logic [GprfTot-1:0]             gprf_sh_q, gprf_act_q;
   logic [CgraTot-1:0]             cgra_sh_q, cgra_act_q;
   logic [CGRA_PIPE_SEL_WIDTH-1:0] lat_sh_q, lat_act_q;
   logic                           done_q;

   assign hs       = in_valid & in_ready;
   assign in_ready = state_q inside {StPred, StGprf, StCgra, StLat, StChk};
   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign predrf_cfg           = pred_act_q;
   assign gprf_cfg             = gprf_act_q;
   assign cgra_cfg             = cgra_act_q;
   assign cgra_compute_latency = lat_act_q;

   always_comb begin
      last_word = '0;
      last_rec  = '0;
      case (state_q)
         StPred: begin last_word = WordW'(PredWords - 1); last_rec = RecW'(NUM_CGRA_IO - 1); end
         StGprf: begin last_word = WordW'(GprfWords - 1); last_rec = RecW'(NUM_CGRA_IO - 1); end
         StCgra: begin last_word = WordW'(CgraWords - 1); last_rec = RecW'(NUM_TILES - 1); end
         default: ;
      endcase
   end

   assign rec_last = (word_q == last_word);
   assign sec_last = rec_last && (rec_q == last_rec);

`ifdef DICE_CFG_LOADER_CHECKSUM_EN
   logic [31:0] csum_q;
   logic        err_q;
`endif

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      rec_d   = rec_q;
      case (state_q)
         StIdle: if (start) state_d = StPred;
         StPred, StGprf, StCgra: begin
            if (hs) begin
               if (!rec_last) begin
                  word_d = word_q + 1'b1;
               end else begin
                  word_d = '0;
                  if (!sec_last) begin
                     rec_d = rec_q + 1'b1;
                  end else begin
                     rec_d   = '0;
                     state_d = (state_q == StPred) ? StGprf :
                               (state_q == StGprf) ? StCgra : StLat;
                  end
               end
            end
         end
`ifdef DICE_CFG_LOADER_CHECKSUM_EN
         StLat: if (hs) state_d = StChk;
         StChk: if (hs) state_d = (in_data == csum_q) ? StCommit : StIdle;
`else
         StLat: if (hs) state_d = StCommit;
`endif
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      // Abort wins over start and over a same-cycle handshake.
      if (clr) begin
         state_d = StIdle;
         word_d  = '0;
         rec_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         word_q  <= '0;
         rec_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         rec_q   <= rec_d;
      end
   end

   // Records shift in from the top so record 0 ends at the bottom of each section.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         pred_sh_q  <= '0;
         gprf_sh_q  <= '0;
         cgra_sh_q  <= '0;
         lat_sh_q   <= '0;
         pred_act_q <= '0;
         gprf_act_q <= '0;
         cgra_act_q <= '0;
         lat_act_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (clr) begin
            pred_sh_q <= '0;
            gprf_sh_q <= '0;
            cgra_sh_q <= '0;
            lat_sh_q  <= '0;
         end else begin
            if (hs) acc_q <= AccW'({acc_q, in_data});
            if (hs && rec_last) begin
               case (state_q)
                  StPred: pred_sh_q <= {PRED_BITS'({acc_q, in_data}),
                                        pred_sh_q[PredTot-1:PRED_BITS]};
                  StGprf: gprf_sh_q <= {GPRF_BITS'({acc_q, in_data}),
                                        gprf_sh_q[GprfTot-1:GPRF_BITS]};
                  StCgra: cgra_sh_q <= {TILE_BITS'({acc_q, in_data}),
                                        cgra_sh_q[CgraTot-1:TILE_BITS]};
                  StLat:  lat_sh_q  <= in_data[CGRA_PIPE_SEL_WIDTH-1:0];
                  default: ;
               endcase
            end
            if (state_q == StCommit) begin
               pred_act_q <= pred_sh_q;
               gprf_act_q <= gprf_sh_q;
               cgra_act_q <= cgra_sh_q;
               lat_act_q  <= lat_sh_q;
               done_q     <= 1'b1;
            end
         end
      end
   end

`ifdef DICE_CFG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
         err_q  <= 1'b0;
      end else if (!clr) begin
         if (state_q == StIdle && start) begin
            csum_q <= '0;
            err_q  <= 1'b0;
         end else if (hs && state_q != StChk) begin
            csum_q <= csum_q ^ in_data;
         end
         if (state_q == StChk && hs && in_data != csum_q) err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/dice_cfg_loader.md
# dice_cfg_loader

Hardware configuration loader for the DICE CGRA subsystem. It consumes a valid/ready stream of 32-bit configuration words and deserializes them into the predicate-RF port config, GPRF port config, CGRA tile bitstream and compute latency that drive `dice_cgra_subsystem`. Loads fill shadow registers. The active outputs change atomically only on successful completion, so a running kernel never sees partial configuration.

## Interface
- `TILE_BITS`, 156, config bits per CGRA tile
- `NUM_TILES`, 16, CGRA tiles
- `NUM_CGRA_IO`, 32, RF I/O ports
- `PRED_BITS`, 8, predicate-RF config bits per port: {rd_en, wr_en, lat_in[2:0], lat_out[2:0]}
- `GPRF_BITS`, 49, GPRF config bits per port
- `CGRA_PIPE_SEL_WIDTH`, 5, compute latency width
- `clk` in 1: clock
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `clr` in 1: synchronous abort of an in-progress load
- `start` in 1: begin a load; honored only in IDLE
- `in_data` in 32: configuration word
- `in_valid` in 1: word valid
- `in_ready` out 1: word accepted when `in_valid & in_ready`
- `predrf_cfg` out `PRED_BITS*NUM_CGRA_IO`: active predicate-RF config
- `gprf_cfg` out `GPRF_BITS*NUM_CGRA_IO`: active GPRF config
- `cgra_cfg` out `TILE_BITS*NUM_TILES`: active tile config
- `cgra_compute_latency` out `CGRA_PIPE_SEL_WIDTH`: active compute latency
- `busy` out 1: load in progress (state ≠ IDLE)
- `done` out 1: one-cycle pulse when the active registers update
- `err` out 1: sticky checksum error; cleared by `start` or `rst`

## Operation
- **States:** IDLE → PRED → GPRF → CGRA → LAT → [CHK] → COMMIT → IDLE.
- **Record framing:**
  - A record of B bits occupies W = ceil(B/32) words, most-significant word first.
  - Word 0 bits `[B-32*(W-1)-1:0]` carry record bits `[B-1:32*(W-1)]`.
  - Upper padding bits of word 0 are ignored.
  - Each later word carries the next 32 bits, descending.
- **Words per record:** PRED 1 (bits `[7:0]`); GPRF 2 (word0 `[16:0]`); CGRA 5 (word0 `[27:0]`).
- **Placement:** record i is written to `shadow[i*B +: B]` of its section. Records arrive in index order 0..N-1.
- **Section lengths:** PRED 32 records, GPRF 32 records, CGRA 16 records. LAT is one word, `[4:0]` → latency. Total 177 words, or 178 with a checksum.
- **Counters:**
  - `word_idx` counts 0..W-1 within a record.
  - `rec_idx` counts 0..N-1 within a section.
  - Both reset to 0 on each section change.
  - A section advances on acceptance of its last word of its last record.
- **COMMIT:** all shadow registers copy to the active outputs; `done` is set; the next state is IDLE.
- **Ignored `start`:** `start` outside IDLE is ignored.
- **Words outside load states:** words presented in IDLE are not consumed (`in_ready=0`).
- **`clr`:**
  - Forces IDLE from any state.
  - Shadow contents are discarded.
  - Active outputs and `err` are retained.
  - `clr` has priority over `start` and over a same-cycle handshake.
- **Simultaneous `start` and `clr` in IDLE:** stay in IDLE.

## Timing
- **Reset values:** all outputs 0, `in_ready` 0, state IDLE, shadows 0.
- **Load start:** `start` sampled in IDLE → next cycle state PRED, `busy=1`, `in_ready=1`.
- **`in_ready`:** decoded from registered state only. It is 1 in PRED, GPRF, CGRA, LAT and CHK; 0 otherwise. There is no combinational path from `in_valid`.
- **Throughput and stalls:** one word per cycle maximum. `in_valid` gaps stall the counters with no loss.
- **Commit latency:** edge accepting the final word → state COMMIT. The next edge updates the active outputs, pulses `done=1` for that cycle, and returns to IDLE. Outputs therefore change 2 edges after the last handshake.
- **Back-to-back loads:** `start` may be asserted in the same cycle `done` is high; it is accepted, since the state is IDLE.
- **Reset mid-load:** clears everything, including the active outputs.

## Configuration
- `DICE_CFG_LOADER_CHECKSUM_EN` defined:
  - LAT is followed by state CHK, which expects one trailer word.
  - The trailer must equal the XOR of all 177 preceding payload words.
  - Match → COMMIT.
  - Mismatch → `err=1`, return to IDLE with no commit and no `done`.
- Not defined: no CHK state, no trailer word; LAT goes directly to COMMIT. `err` is tied 0.

## Test plan
- **Reset:** assert `rst` 3 cycles → all cfg outputs 0, `busy=0`, `in_ready=0`, `done=0`.
- **Full load:** full 177-word load at one word per cycle, where:
  - PRED word i = `0xFFFFFF00|i`;
  - GPRF words = `{0xFFFE0000|i, 0xA5A50000|i}`;
  - CGRA word0 = `0xF0000000|i`, the other CGRA words = i;
  - LAT = 28.

  Required response:
  - `predrf_cfg[i*8+:8]==i`;
  - `gprf_cfg[i*49+:49]=={17'(i),32'hA5A50000|i}` (padding ignored);
  - tile record i `=={28'(i),32'(i),32'(i),32'(i),32'(i)}`;
  - latency 28;
  - `done` pulses exactly 2 edges after the last handshake.
- **Stalls:** same load with random `in_valid` gaps → identical outputs; `done` is never early; no words are dropped or duplicated.
- **Persistence across abort:**
  1. Load pattern A.
  2. Start pattern B and assert `clr` after 50 words → `busy=0` next cycle, outputs still A, no `done`.
  3. Reload B → outputs B.
- **Handshake guards:** `start` during PRED is ignored (word count unaffected); words offered in IDLE are not consumed.
- **Checksum (`DICE_CFG_LOADER_CHECKSUM_EN`):**
  - Correct XOR trailer → commit.
  - Trailer XOR 1 → `err=1`, outputs unchanged, no `done`.
  - Next `start` clears `err`.
